// File: rtl/periph_req_arbiter.sv
// Round-robin arbiter that shares one peripheral slave port between N_CORES cores.
// Responses come back in issue order and are routed to their originating core.
module periph_req_arbiter #(
  parameter int N_CORES    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CORES-1:0]             m_req_i,
  input  logic [N_CORES*ADDR_WIDTH-1:0]  m_add_i,
  input  logic [N_CORES-1:0]             m_type_i,
  input  logic [N_CORES*DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [N_CORES*BE_WIDTH-1:0]    m_be_i,
  output logic [N_CORES-1:0]             m_gnt_o,
  output logic [N_CORES-1:0]             m_r_valid_o,
  output logic [DATA_WIDTH-1:0]          m_r_rdata_o,
  output logic                           m_r_opc_o,
  output logic [N_CORES-1:0]             m_busy_o,
  output logic                           s_req_o,
  output logic [ADDR_WIDTH-1:0]          s_add_o,
  output logic                           s_type_o,
  output logic [DATA_WIDTH-1:0]          s_wdata_o,
  output logic [BE_WIDTH-1:0]            s_be_o,
  input  logic                           s_gnt_i,
  input  logic                           s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          s_r_rdata_i,
  input  logic                           s_r_opc_i,
  output logic                           err_o
);

  localparam int IDX_W = $clog2(N_CORES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     off;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     head;
  logic [IDX_W:0]       win_sum;
  logic [2*N_CORES-1:0] req_dbl;
  logic [2*N_CORES-1:0] req_rot;
  logic                 any_req;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 err_q;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     fifo_mem [DEPTH];
  logic [CNT_W-1:0]     core_cnt [N_CORES];

  // Rotate the request vector so the scan always starts at rr_ptr.
  always_comb begin
    req_dbl = {m_req_i, m_req_i};
    req_rot = req_dbl >> rr_ptr;
    any_req = 1'b0;
    off     = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (!any_req && req_rot[k]) begin
        any_req = 1'b1;
        off     = IDX_W'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (win_sum >= (IDX_W+1)'(N_CORES)) begin
      win_sum = win_sum - (IDX_W+1)'(N_CORES);
    end
    win = any_req ? win_sum[IDX_W-1:0] : '0;
  end

  assign full    = (count == CNT_W'(DEPTH));
  assign s_req_o = any_req & ~full;
  assign push    = s_req_o & s_gnt_i;
  assign pop     = s_r_valid_i & (count != '0);
  assign head    = fifo_mem[rd_ptr];

  assign s_add_o   = m_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_type_o  = m_type_i[win];
  assign s_wdata_o = m_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign s_be_o    = m_be_i[int'(win)*BE_WIDTH +: BE_WIDTH];

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;
  assign err_o       = err_q;

  always_comb begin
    m_gnt_o     = '0;
    m_r_valid_o = '0;
    m_busy_o    = '0;
    for (int i = 0; i < N_CORES; i++) begin
      m_gnt_o[i]     = push && (win == IDX_W'(i));
      m_r_valid_o[i] = pop && (head == IDX_W'(i));
      m_busy_o[i]    = (core_cnt[i] != '0);
    end
  end

  // Control state: arbitration pointer, FIFO pointers/occupancy, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (win == IDX_W'(N_CORES - 1)) ? '0 : win + IDX_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_r_valid_i && (count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Per-core outstanding counters; a push and pop for the same core cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CORES; i++) begin
        core_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if ((push && (win == IDX_W'(i))) && !(pop && (head == IDX_W'(i)))) begin
          core_cnt[i] <= core_cnt[i] + CNT_W'(1);
        end else if ((pop && (head == IDX_W'(i))) && !(push && (win == IDX_W'(i)))) begin
          core_cnt[i] <= core_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // ID storage holds only data; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= win;
    end
  end

endmodule

// File: tb/tb_periph_req_arbiter.sv
// Randomized and directed bench for periph_req_arbiter with a queue-based reference model.
module tb_periph_req_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req_i;
  logic [N*AW-1:0] m_add_i;
  logic [N-1:0]    m_type_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N*BW-1:0] m_be_i;
  logic [N-1:0]    m_gnt_o;
  logic [N-1:0]    m_r_valid_o;
  logic [DW-1:0]   m_r_rdata_o;
  logic            m_r_opc_o;
  logic [N-1:0]    m_busy_o;
  logic            s_req_o;
  logic [AW-1:0]   s_add_o;
  logic            s_type_o;
  logic [DW-1:0]   s_wdata_o;
  logic [BW-1:0]   s_be_o;
  logic            s_gnt_i;
  logic            s_r_valid_i;
  logic [DW-1:0]   s_r_rdata_i;
  logic            s_r_opc_i;
  logic            err_o;

  always #5 clk = ~clk;

  periph_req_arbiter #(
    .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_type_i(m_type_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
    .m_r_opc_o(m_r_opc_o), .m_busy_o(m_busy_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_type_o(s_type_o),
    .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_rdata_i(s_r_rdata_i),
    .s_r_opc_i(s_r_opc_i), .err_o(err_o)
  );

  typedef struct packed {
    logic          sreq;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [N-1:0]  busy;
    logic          err;
    logic [AW-1:0] add;
  } cyc_t;

  typedef struct packed {
    logic [7:0]    core;
    logic [AW-1:0] add;
    logic          typ;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } hs_t;

  typedef struct packed {
    logic [7:0]    core;
    logic [DW-1:0] rdata;
    logic          opc;
  } rsp_t;

  cyc_t cyc_q[$];
  hs_t  hs_q[$];
  rsp_t rsp_q[$];

  // Reference model: list of outstanding core IDs in issue order.
  int   outq[$];
  int   rr;
  logic err_m;

  logic [AW-1:0] pay_add   [N];
  logic          pay_type  [N];
  logic [DW-1:0] pay_wdata [N];
  logic [BW-1:0] pay_be    [N];

  int   n_chk  = 0;
  int   n_fail = 0;
  logic last_hs;
  int   last_win;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_payloads();
    for (int i = 0; i < N; i++) begin
      pay_add[i]   = $urandom;
      pay_type[i]  = 1'($urandom_range(0, 1));
      pay_wdata[i] = $urandom;
      pay_be[i]    = 4'($urandom_range(0, 15));
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, predict, then advance the model.
  task automatic cycle(input logic [N-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rdata, input logic opc);
    int   n, w, idx;
    logic any, hs, pp;
    cyc_t c;
    hs_t  h;
    rsp_t r;
    @(negedge clk);
    m_req_i = req; s_gnt_i = gnt; s_r_valid_i = rv; s_r_rdata_i = rdata; s_r_opc_i = opc;
    for (int i = 0; i < N; i++) begin
      m_add_i[i*AW +: AW]   = pay_add[i];
      m_type_i[i]           = pay_type[i];
      m_wdata_i[i*DW +: DW] = pay_wdata[i];
      m_be_i[i*BW +: BW]    = pay_be[i];
    end
    n = outq.size();
    any = 1'b0;
    w = 0;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        w = idx;
      end
    end
    hs = any && (n < DEPTH) && gnt;
    pp = rv && (n > 0);
    c = '0;
    c.sreq = any && (n < DEPTH);
    if (hs) c.gnt[w] = 1'b1;
    if (pp) c.rvalid[outq[0]] = 1'b1;
    foreach (outq[j]) c.busy[outq[j]] = 1'b1;
    c.err = err_m;
    c.add = pay_add[w];
    cyc_q.push_back(c);
    if (hs) begin
      h.core = 8'(w); h.add = pay_add[w]; h.typ = pay_type[w];
      h.wdata = pay_wdata[w]; h.be = pay_be[w];
      hs_q.push_back(h);
    end
    if (pp) begin
      r.core = 8'(outq[0]); r.rdata = rdata; r.opc = opc;
      rsp_q.push_back(r);
      void'(outq.pop_front());
    end
    if (hs) begin
      outq.push_back(w);
      rr = (w + 1) % N;
    end
    if (rv && n == 0) err_m = 1'b1;
    last_hs = hs;
    last_win = w;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) cycle('0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic respond(input logic [DW-1:0] rdata, input logic opc);
    cycle('0, 1'b0, 1'b1, rdata, opc);
  endtask

  // Asynchronous reset mid-cycle, away from any clock edge.
  task automatic reset_mid();
    #6;
    m_req_i = '0; s_gnt_i = 1'b0; s_r_valid_i = 1'b0;
    rst_n = 1'b0;
    outq.delete();
    rr = 0;
    err_m = 1'b0;
    #1;
    chk("rst_busy", m_busy_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_sreq", s_req_o, 1'b0);
    chk("rst_rvalid", m_r_valid_o, '0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    cyc_t c;
    hs_t  h;
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("s_req", s_req_o, c.sreq);
        chk("m_gnt", m_gnt_o, c.gnt);
        chk("m_r_valid", m_r_valid_o, c.rvalid);
        chk("m_busy", m_busy_o, c.busy);
        chk("err", err_o, c.err);
        chk("s_add", s_add_o, c.add);
        if (s_req_o && s_gnt_i) begin
          if (hs_q.size() == 0) begin
            chk("hs_unexpected", 1'b1, 1'b0);
          end else begin
            h = hs_q.pop_front();
            chk("hs_gnt", m_gnt_o, 64'(1) << h.core);
            chk("hs_add", s_add_o, h.add);
            chk("hs_type", s_type_o, h.typ);
            chk("hs_wdata", s_wdata_o, h.wdata);
            chk("hs_be", s_be_o, h.be);
          end
        end
        if (m_r_valid_o != '0) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_core", m_r_valid_o, 64'(1) << r.core);
            chk("rsp_rdata", m_r_rdata_o, r.rdata);
            chk("rsp_opc", m_r_opc_o, r.opc);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] pend;
    logic         rv;
    rst_n = 1'b0;
    m_req_i = '0; m_add_i = '0; m_type_i = '0; m_wdata_i = '0; m_be_i = '0;
    s_gnt_i = 1'b0; s_r_valid_i = 1'b0; s_r_rdata_i = '0; s_r_opc_i = 1'b0;
    rr = 0; err_m = 1'b0;
    load_payloads();
    #2;
    chk("init_sreq", s_req_o, 1'b0);
    chk("init_gnt", m_gnt_o, '0);
    chk("init_busy", m_busy_o, '0);
    chk("init_err", err_o, 1'b0);
    #1 rst_n = 1'b1;

    // Single read from core 2, answered one cycle later.
    pay_add[2] = 32'h1A00_0010; pay_type[2] = 1'b1;
    cycle(4'b0100, 1'b1, 1'b0, '0, 1'b0);
    respond(32'hDEAD_BEEF, 1'b0);
    idle(1);
    reset_mid();

    // All cores request until the FIFO fills, then a pop collides with a blocked request.
    load_payloads();
    repeat (5) cycle(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0, '0, 1'b0);
    repeat (4) respond($urandom, 1'($urandom_range(0, 1)));
    idle(1);

    // Ordered return 3,1,3 with an error flag on the middle response.
    load_payloads();
    cycle(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0, '0, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    respond(32'hA, 1'b0);
    respond(32'hB, 1'b1);
    respond(32'hC, 1'b0);
    idle(1);

    // Stalled slave with rr_ptr at 1: core 0 joining must not preempt core 1.
    cycle(4'b0001, 1'b1, 1'b0, '0, 1'b0);
    respond(32'h1, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0, '0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0, '0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0, '0, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0, '0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0, '0, 1'b0);
    respond(32'h2, 1'b0);
    respond(32'h3, 1'b0);
    idle(1);

    // Spurious response, then reset with two outstanding, then spurious again.
    respond(32'hBAD, 1'b1);
    idle(2);
    cycle(4'b0100, 1'b1, 1'b0, '0, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    reset_mid();
    respond(32'hBAD2, 1'b0);
    idle(2);
    reset_mid();

    // Random traffic; cores hold request and payload until granted.
    pend = '0;
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]      = 1'b1;
          pay_add[i]   = $urandom;
          pay_type[i]  = 1'($urandom_range(0, 1));
          pay_wdata[i] = $urandom;
          pay_be[i]    = 4'($urandom_range(0, 15));
        end
      end
      rv = ($urandom_range(0, 1) == 1) && ((outq.size() > 0) || ($urandom_range(0, 40) == 0));
      cycle(pend, $urandom_range(0, 3) != 0, rv, $urandom, 1'($urandom_range(0, 1)));
      if (last_hs) pend[last_win] = 1'b0;
    end
    idle(3);
    @(negedge clk);
    #4;
    chk("hs_q_drained", 64'(hs_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
